// File: rtl/board_renderer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_renderer_pkg
//  Description : Shared screen package for the board renderer: board geometry,
//                coordinate/color widths, glyph position type, FSM state type
//                and the pixel/tag records carried through the datapath.
//                The grid field of the tag record exists only when the
//                RENDER_GRID_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package board_renderer_pkg;

  localparam int c_BOARD_DIM   = 9;
  localparam int c_CELL_COUNT  = 81;
  localparam int c_CELL_PX_DEF = 40;
  localparam int c_POS_W       = 6;
  localparam int c_COORD_W     = 9;
  localparam int c_COLOR_W     = 3;
  localparam int c_ADDR_W      = 7;
  localparam int c_DIGIT_W     = 4;
  localparam logic [2:0] c_GRID_COLOR = 3'b010;

  // Line/pixel position inside one glyph cell.
  typedef struct packed {
    logic [c_POS_W-1:0] line;
    logic [c_POS_W-1:0] pixel;
  } pos_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One finished pixel as held in the output buffer.
  typedef struct packed {
    logic [c_COORD_W-1:0] x;
    logic [c_COORD_W-1:0] y;
    logic [c_COLOR_W-1:0] color;
  } px_t;

  // Bookkeeping that travels alongside an outstanding glyph lookup.
  typedef struct packed {
    logic                 valid;
    logic [c_COORD_W-1:0] x;
    logic [c_COORD_W-1:0] y;
`ifdef RENDER_GRID_EN
    logic                 grid;
`endif
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/board_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module      : board_renderer_if
//  Description : Bundle of the render control, board-memory, glyph-lookup and
//                pixel-stream signals. The renderer uses the master modport,
//                the surrounding system uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface board_renderer_if;
  import board_renderer_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [c_ADDR_W-1:0]  cell_addr;
  logic [c_DIGIT_W-1:0] cell_digit;
  logic [c_DIGIT_W-1:0] glyph_digit;
  pos_t                 glyph_pos;
  logic [c_COLOR_W-1:0] glyph_color;
  logic                 px_valid;
  logic                 px_ready;
  logic [c_COORD_W-1:0] px_x;
  logic [c_COORD_W-1:0] px_y;
  logic [c_COLOR_W-1:0] px_color;

  modport master (
    input  start, cell_digit, glyph_color, px_ready,
    output busy, done, cell_addr, glyph_digit, glyph_pos,
           px_valid, px_x, px_y, px_color
  );

  modport slave (
    output start, cell_digit, glyph_color, px_ready,
    input  busy, done, cell_addr, glyph_digit, glyph_pos,
           px_valid, px_x, px_y, px_color
  );

endinterface
`default_nettype wire

// File: rtl/board_renderer_pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fifo
//  Description : Synchronous FIFO used as the renderer's pixel output buffer.
//                First-word-fall-through head, full/empty/count status.
//                A push on a full FIFO is accepted when a pop happens in the
//                same cycle, leaving occupancy unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 21,
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int c_CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [c_CNT_W-1:0] o_count
);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == c_CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/board_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : board_renderer
//  Description : Renders a 9x9 digit board to a pixel stream. Each cell digit
//                is fetched from board memory, every glyph pixel is looked up
//                in a fixed-latency font ROM, and results are buffered in a
//                credit-controlled output FIFO drained by a valid/ready sink.
//                Optional feature macro: RENDER_GRID_EN (draws cell borders
//                on line 0 / pixel 0 of every cell in the grid color).
//  Revision    : 1.0 - initial release
// ============================================================================
module board_renderer
  import board_renderer_pkg::*;
#(
  parameter int FONT_LAT   = 2,
  parameter int CELL_PX    = c_CELL_PX_DEF,
  parameter int FIFO_DEPTH = FONT_LAT + 2
) (
  input  logic             clk,
  input  logic             rst,
  board_renderer_if.master bus
);

  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_POS_W-1:0]   c_LAST_POS  = c_POS_W'(CELL_PX - 1);
  localparam logic [c_ADDR_W-1:0]  c_LAST_CELL = c_ADDR_W'(c_CELL_COUNT - 1);
  localparam logic [3:0]           c_LAST_COL  = 4'(c_BOARD_DIM - 1);
  localparam logic [c_COORD_W-1:0] c_CELL_STEP = c_COORD_W'(CELL_PX);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_ADDR_W-1:0]   r_cell_idx;
  logic [3:0]            r_col;
  logic [c_COORD_W-1:0]  r_x_base;
  logic [c_COORD_W-1:0]  r_y_base;
  logic                  r_fetch_ph;
  logic [c_DIGIT_W-1:0]  r_digit;
  logic [c_POS_W-1:0]    r_line;
  logic [c_POS_W-1:0]    r_pix;
  tag_t                  r_tag [FONT_LAT];

  tag_t                  w_new_tag;
  px_t                   w_push_px;
  px_t                   w_head;
  logic                  w_issue;
  logic                  w_last_px;
  logic [7:0]            w_inflight;
  logic [7:0]            w_used;
  logic                  w_credit_ok;
  logic                  w_tags_empty;
  logic                  w_drain_done;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [c_CNT_W-1:0]    w_fifo_count;

  // Count outstanding lookups still travelling through the tag pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < FONT_LAT; i++) begin
      w_inflight = w_inflight + 8'(r_tag[i].valid);
    end
  end

  // A lookup may only be issued when a FIFO slot is guaranteed for its result.
  assign w_used       = w_inflight + 8'(w_fifo_count);
  assign w_credit_ok  = !w_fifo_full && (w_used < 8'(FIFO_DEPTH));
  assign w_tags_empty = (w_inflight == 8'd0);
  assign w_last_px    = (r_line == c_LAST_POS) && (r_pix == c_LAST_POS);
  assign w_pop        = !w_fifo_empty && bus.px_ready;
  // Leave DRAIN on the cycle the final pixel is accepted so done follows it directly.
  assign w_drain_done = w_tags_empty &&
                        (w_fifo_empty || ((w_fifo_count == c_CNT_W'(1)) && w_pop));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and lookup-issue decode.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_FETCH;
      ST_FETCH: if (r_fetch_ph) w_state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (w_last_px) begin
            w_state_nxt = (r_cell_idx == c_LAST_CELL) ? ST_DRAIN : ST_FETCH;
          end
        end
      end
      ST_DRAIN: if (w_drain_done) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Cell walk, digit latch and line-major glyph scan counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cell_idx <= '0;
      r_col      <= '0;
      r_x_base   <= '0;
      r_y_base   <= '0;
      r_fetch_ph <= 1'b0;
      r_digit    <= '0;
      r_line     <= '0;
      r_pix      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_cell_idx <= '0;
            r_col      <= '0;
            r_x_base   <= '0;
            r_y_base   <= '0;
            r_fetch_ph <= 1'b0;
            r_line     <= '0;
            r_pix      <= '0;
          end
        end
        ST_FETCH: begin
          // Phase 0 presents the address, phase 1 captures the returned digit.
          r_fetch_ph <= ~r_fetch_ph;
          if (r_fetch_ph) r_digit <= bus.cell_digit;
        end
        ST_SCAN: begin
          if (w_issue) begin
            if (r_pix == c_LAST_POS) begin
              r_pix <= '0;
              if (r_line == c_LAST_POS) begin
                r_line <= '0;
                if (r_cell_idx != c_LAST_CELL) begin
                  r_cell_idx <= r_cell_idx + 1'b1;
                  if (r_col == c_LAST_COL) begin
                    r_col    <= '0;
                    r_x_base <= '0;
                    r_y_base <= r_y_base + c_CELL_STEP;
                  end else begin
                    r_col    <= r_col + 1'b1;
                    r_x_base <= r_x_base + c_CELL_STEP;
                  end
                end
              end else begin
                r_line <= r_line + 1'b1;
              end
            end else begin
              r_pix <= r_pix + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tag for the lookup being issued this cycle.
  always_comb begin
    w_new_tag       = '0;
    w_new_tag.valid = w_issue;
    w_new_tag.x     = r_x_base + c_COORD_W'(r_pix);
    w_new_tag.y     = r_y_base + c_COORD_W'(r_line);
`ifdef RENDER_GRID_EN
    w_new_tag.grid  = (r_line == '0) || (r_pix == '0);
`endif
  end

  // Tag pipeline matching the font latency; reset drops all outstanding lookups.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FONT_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_new_tag;
      for (int i = 1; i < FONT_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Join the emerging tag with the glyph color it was waiting for.
  always_comb begin
    w_push_px.x = r_tag[FONT_LAT-1].x;
    w_push_px.y = r_tag[FONT_LAT-1].y;
`ifdef RENDER_GRID_EN
    w_push_px.color = r_tag[FONT_LAT-1].grid ? c_GRID_COLOR : bus.glyph_color;
`else
    w_push_px.color = bus.glyph_color;
`endif
  end

  assign w_push = r_tag[FONT_LAT-1].valid;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(px_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_px),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.cell_addr   = r_cell_idx;
  assign bus.glyph_digit = r_digit;
  assign bus.glyph_pos   = '{line: r_line, pixel: r_pix};
  assign bus.px_valid    = !w_fifo_empty;
  assign bus.px_x        = w_head.x;
  assign bus.px_y        = w_head.y;
  assign bus.px_color    = w_head.color;

endmodule
`default_nettype wire

// File: tb/tb_board_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_renderer
//  Description : Self-checking bench for board_renderer with a 4-pixel cell
//                (1296 pixels per render). Board memory and a two-stage glyph
//                ROM are modelled here; every expected pixel is queued at
//                render start and popped as the sink accepts pixels.
//                Honours RENDER_GRID_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_renderer;
  import board_renderer_pkg::*;

  localparam int CPX   = 4;
  localparam int LAT   = 2;
  localparam int NPIX  = 81 * CPX * CPX;

  logic clk;
  logic rst;
  board_renderer_if bus ();

  board_renderer #(.FONT_LAT(LAT), .CELL_PX(CPX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          hs_count = 0;
  int          hs_base = 0;
  int          n_done = 0;
  int          done_base = 0;
  int          done_cyc = 0;
  int          last_hs_cyc = 0;
  logic [3:0]  board [81];
  logic [2:0]  gpipe [LAT];
  logic        g_const = 1'b1;
  logic        rdy_mode = 1'b0;
  logic [20:0] sb [$];
  logic [17:0] first_xy, last_xy, c10_xy;
  logic [2:0]  probe_a, probe_g;
  logic        hold_pend = 1'b0;
  logic [20:0] hold_val;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  function automatic logic [2:0] glyph_fn(input logic [3:0] d, input logic [5:0] l,
                                          input logic [5:0] p);
    if (g_const) return 3'b001;
    return 3'(d * 3 + l * 5 + p * 7 + {2'b0, d ^ l[3:0]});
  endfunction

  function automatic logic [2:0] exp_color(input logic [3:0] d, input logic [5:0] l,
                                           input logic [5:0] p);
`ifdef RENDER_GRID_EN
    if (l == 6'd0 || p == 6'd0) return 3'b010;
`endif
    return glyph_fn(d, l, p);
  endfunction

  // Board memory: one-cycle read latency.
  always @(posedge clk) bus.cell_digit <= board[bus.cell_addr];

  // Glyph ROM: LAT-cycle pipelined lookup.
  always @(posedge clk) begin
    gpipe[0] <= glyph_fn(bus.glyph_digit, bus.glyph_pos.line, bus.glyph_pos.pixel);
    for (int i = 1; i < LAT; i++) gpipe[i] <= gpipe[i-1];
  end
  assign bus.glyph_color = gpipe[LAT-1];

  // Sink ready: always 1, or about 30% duty.
  initial begin
    bus.px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.px_ready = rdy_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      logic [20:0] cur;
      int idx;
      cur = {bus.px_x, bus.px_y, bus.px_color};
      if (bus.px_valid && hold_pend) chk("hold_stable", 32'(cur), 32'(hold_val));
      hold_pend = bus.px_valid && !bus.px_ready;
      hold_val  = cur;
      if (bus.px_valid && bus.px_ready) begin
        idx = hs_count - hs_base;
        if (idx == 0)        first_xy = {bus.px_x, bus.px_y};
        if (idx == NPIX - 1) last_xy  = {bus.px_x, bus.px_y};
        if (idx == 10 * CPX * CPX) c10_xy = {bus.px_x, bus.px_y};
        if (bus.px_x == 9'd3 && bus.px_y == 9'd2) probe_a = bus.px_color;
        if (bus.px_x == 9'd4 && bus.px_y == 9'd3) probe_g = bus.px_color;
        hs_count++;
        last_hs_cyc = cyc;
        if (sb.size() == 0) chk("extra_px", 32'd1, 32'd0);
        else chk("px", 32'(cur), 32'(sb.pop_front()));
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic start_render();
    sb.delete();
    for (int c = 0; c < 81; c++)
      for (int l = 0; l < CPX; l++)
        for (int p = 0; p < CPX; p++)
          sb.push_back({9'((c % 9) * CPX + p), 9'((c / 9) * CPX + l),
                        exp_color(board[c], 6'(l), 6'(p))});
    hs_base   = hs_count;
    done_base = n_done;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic finish_render(input string tag, input int budget);
    int k = 0;
    while (n_done == done_base && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    chk({tag, "_done_seen"}, 32'(n_done != done_base), 32'd1);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_count"}, 32'(hs_count - hs_base), 32'(NPIX));
    chk({tag, "_done_lat"}, 32'(done_cyc - last_hs_cyc), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    bus.start = 1'b0;
    for (int c = 0; c < 81; c++) board[c] = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_px_valid", 32'(bus.px_valid), 32'd0);
    chk("rst_cell_addr", 32'(bus.cell_addr), 32'd0);
    chk("rst_glyph_digit", 32'(bus.glyph_digit), 32'd0);
    chk("rst_glyph_pos", 32'(bus.glyph_pos), 32'd0);
    rst = 1'b0;

    // Empty board, constant glyph color, sink always ready.
    g_const = 1'b1;
    start_render();
    finish_render("allzero", 3000);
    chk("first_xy", 32'(first_xy), 32'd0);
    chk("last_xy", 32'(last_xy), 32'({9'd35, 9'd35}));
    chk("idle_after_done", 32'(bus.busy), 32'd0);

    // Patterned board and glyph function.
    g_const = 1'b0;
    for (int c = 0; c < 81; c++) board[c] = 4'($urandom_range(0, 9));
    board[0]  = 4'd5;
    board[10] = 4'd7;
    start_render();
    finish_render("pattern", 3000);
    chk("px_3_2_color", 32'(probe_a), 32'(glyph_fn(4'd5, 6'd2, 6'd3)));
    chk("cell10_xy", 32'(c10_xy), 32'({9'd4, 9'd4}));
`ifdef RENDER_GRID_EN
    chk("grid_4_3_color", 32'(probe_g), 32'd2);
`endif

    // Empty board again with a sparse ready: identical expected sequence.
    g_const = 1'b1;
    for (int c = 0; c < 81; c++) board[c] = 4'd0;
    rdy_mode = 1'b1;
    start_render();
    finish_render("rand_ready", 12000);
    rdy_mode = 1'b0;

    // Reset in the middle of a render, then render again.
    g_const = 1'b0;
    for (int c = 0; c < 81; c++) board[c] = 4'($urandom_range(0, 9));
    start_render();
    k = 0;
    while ((hs_count - hs_base) < 500 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk("reach_500", 32'((hs_count - hs_base) >= 500), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_px", 32'(bus.px_valid), 32'd0);
    end
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    start_render();
    finish_render("after_rst", 3000);
    chk("after_rst_first_xy", 32'(first_xy), 32'd0);

    // A start pulse during a render must be ignored.
    start_render();
    k = 0;
    while ((hs_count - hs_base) < 300 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    finish_render("restart", 3000);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("single_done", 32'(n_done - done_base), 32'd1);
    chk("restart_idle", 32'(bus.busy), 32'd0);
    chk("restart_no_px", 32'(bus.px_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_renderer.md
BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 Parameter: FONT_LAT, 2, posedge cycles from glyph_digit/glyph_pos presented to matching glyph_color valid.
REQ-002 Parameter: CELL_PX, 40, glyph edge length in pixels; a cell is CELL_PX x CELL_PX.
REQ-003 Parameter: FIFO_DEPTH, FONT_LAT+2, pixel output buffer entries.
REQ-004 Port: clk  in  1  single clock; all logic on posedge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: start  in  1  one-cycle render request.
REQ-007 Port: busy  out  1  high from accepted start until done.
REQ-008 Port: done  out  1  one-cycle pulse after the last pixel is accepted.
REQ-009 Port: cell_addr  out  7  board cell index 0..80, row-major.
REQ-010 Port: cell_digit  in  4  board digit (0 = empty), valid one cycle after cell_addr.
REQ-011 Port: glyph_digit  out  4  digit to the glyph lookup.
REQ-012 Port: glyph_pos  out  position  line/pixel within the glyph.
REQ-013 Port: glyph_color  in  3  color code returned FONT_LAT cycles later.
REQ-014 Port: px_valid  out  1  pixel available.
REQ-015 Port: px_ready  in  1  sink accepts pixel when px_valid and px_ready are both high.
REQ-016 Port: px_x, px_y  out  9 each  screen coordinates: col*CELL_PX+pixel, row*CELL_PX+line.
REQ-017 Port: px_color  out  3  pixel color code.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, SCAN, DRAIN, DONE.
REQ-019 IDLE: start moves to FETCH with cell index 0; start while busy SHALL be ignored.
REQ-020 FETCH: drive cell_addr for one cycle; latch cell_digit on the next cycle; then enter SCAN.
REQ-021 SCAN: issue at most one lookup per cycle, line-major then pixel (0..CELL_PX-1 each); glyph_digit holds the latched digit.
REQ-022 Issue SHALL occur only when in-flight count + FIFO occupancy < FIFO_DEPTH (credit rule); FIFO SHALL never overflow.
REQ-023 Each issue pushes a valid bit, x and y into a FONT_LAT-deep tag pipeline; glyph_color is written to the FIFO with its tag when the valid bit emerges.
REQ-024 Last pixel of a cell: cell 80 -> DRAIN, else FETCH with cell index+1.
REQ-025 DRAIN: wait until the tag pipeline and FIFO are empty, then DONE; DONE asserts done one cycle and returns to IDLE.
REQ-026 Output is the FIFO head; px_valid = FIFO not empty; pop on handshake; pixels SHALL leave in issue order, none dropped or duplicated.
REQ-027 px_x/px_y/px_color SHALL stay stable while px_valid is high and px_ready is low.
REQ-028 Simultaneous push and pop on a full FIFO SHALL be legal; occupancy is unchanged.
REQ-029 Total per render: 81*CELL_PX*CELL_PX pixels (129600 at default).

Reset
REQ-030 rst SHALL asynchronously force IDLE, busy=0, done=0, px_valid=0, cell_addr=0, glyph_digit=0, glyph_pos=0, and clear the FIFO, tag pipeline and counters.
REQ-031 A lookup returning after reset mid-SCAN SHALL be discarded; no px_valid until the next start.

Configuration
REQ-032 Macro RENDER_GRID_EN defined: pixels with line==0 or pixel==0 SHALL be written with color 3'b010 in place of glyph_color.
REQ-033 RENDER_GRID_EN undefined: glyph_color passes unmodified; no grid logic synthesized.

Structure
REQ-034 The position type comes from the shared screen package; CELL_PX default, board dimension 9, cell count 81 and grid color 3'b010 SHALL be added there as constants.
REQ-035 Output buffer SHALL be one sub-module, pixel_fifo (parameterized depth and width, full/empty/count).

Verification
REQ-036 Board all 0, glyph model returns 3'b001, px_ready=1: 129600 pixels of color 3'b001, first (0,0), last (359,359), done one cycle after the last handshake.
REQ-037 Cell 0 = 5, glyph model = f(digit,line,pixel), px_ready=1: pixel (7,3) color = f(5,3,7); cell 10 at pixel (0,0) -> coordinates (40,40).
REQ-038 px_ready random 30% duty: sequence identical to the REQ-036 run; the in-flight-plus-occupancy scoreboard never exceeds FIFO_DEPTH.
REQ-039 rst pulsed at pixel 5000, then start: no stale pixel, output restarts at (0,0), count 129600.
REQ-040 start pulsed mid-render: ignored, one done only; with RENDER_GRID_EN, pixel (40,17) has color 3'b010.
